// File: rtl/delay_arb_pkg.sv
// Shared types for the delay arbiter: FSM state encoding and index-width helper.
package delay_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_COUNT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/delay_counter.sv
// Loadable saturating down-counter timing one granted delay.
module delay_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         terminal
);

  logic [W-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= value;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  // At most one decrement left: the next cycle is the last one of the delay.
  assign terminal = (count_q[W-1:1] == '0);

endmodule

// File: rtl/delay_arbiter.sv
// Round-robin arbiter that grants one requester at a time and times its
// requested delay, pulsing done for that requester on the last busy cycle.
module delay_arbiter
  import delay_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ-1:0][W-1:0]     cycles,
  output logic                        busy,
  output logic [idx_width(N_REQ)-1:0] grant_id,
  output logic [N_REQ-1:0]            done
);

  localparam int IW = idx_width(N_REQ);

  state_e            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     gid_q, gid_d;
  logic              busy_q, busy_d;
  logic [N_REQ-1:0]  done_q, done_d;

  logic [IW-1:0]     sel_lo, sel_hi, sel_idx;
  logic              hit_hi;
  logic [W-1:0]      sel_cycles, load_value;
  logic              load, terminal;

  // Round-robin pick: lowest requester at or above ptr, else lowest overall.
  always_comb begin
    sel_lo = '0;
    sel_hi = '0;
    hit_hi = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        sel_lo = IW'(i);
        if (IW'(i) >= ptr_q) begin
          sel_hi = IW'(i);
          hit_hi = 1'b1;
        end
      end
    end
    sel_idx = hit_hi ? sel_hi : sel_lo;
  end

  // The counter holds D-1 so that a zero request still times a single cycle.
  assign sel_cycles = cycles[sel_idx];
  assign load_value = (sel_cycles == '0) ? '0 : sel_cycles - 1'b1;

  // NOTE: every variable gets a default at the top of the block, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    busy_d  = busy_q;
    done_d  = '0;
    load    = 1'b0;
    case (state_q)
      // DONE arbitrates like IDLE so back-to-back grants are D+1 cycles apart.
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        if (req != '0) begin
          state_d         = ST_COUNT;
          busy_d          = 1'b1;
          gid_d           = sel_idx;
          ptr_d           = (int'(sel_idx) == N_REQ - 1) ? '0 : sel_idx + 1'b1;
          load            = 1'b1;
          done_d[sel_idx] = (sel_cycles[W-1:1] == '0);
        end
      end
      ST_COUNT: begin
        if (done_q != '0 || !req[gid_q]) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
        end else if (terminal) begin
          done_d[gid_q] = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  delay_counter #(.W(W)) u_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .value    (load_value),
    .terminal (terminal)
  );

  assign busy     = busy_q;
  assign grant_id = gid_q;
  assign done     = done_q;

endmodule

// File: tb/tb_delay_arbiter.sv
// Self-checking bench for delay_arbiter: directed scenarios plus random traffic
// compared each cycle against a busy-cycles-remaining reference model.
module tb_delay_arbiter;

  localparam int N = 4;
  localparam int W = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [N-1:0]       req;
  logic [N-1:0][W-1:0] cycles;
  logic               busy;
  logic [1:0]         grant_id;
  logic [N-1:0]       done;

  delay_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .cycles   (cycles),
    .busy     (busy),
    .grant_id (grant_id),
    .done     (done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who owns the block and how many busy cycles it has left.
  logic         m_busy;
  logic [N-1:0] m_done;
  int           m_owner, m_left, m_ptr, m_pick;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 1'b0; m_done = '0; m_owner = 0; m_left = 0; m_ptr = 0;
    end else if (m_busy) begin
      if (m_done != '0) begin
        m_busy = 1'b0;
        m_done = '0;
      end else if (!req[m_owner]) begin
        m_busy = 1'b0;
      end else begin
        m_left = m_left - 1;
        if (m_left == 1) m_done = N'(1) << m_owner;
      end
    end else if (req != '0) begin
      m_pick = -1;
      for (int k = 0; k < N; k++)
        if (m_pick < 0 && req[(m_ptr + k) % N]) m_pick = (m_ptr + k) % N;
      m_owner = m_pick;
      m_left  = (cycles[m_pick] == '0) ? 1 : int'(cycles[m_pick]);
      m_done  = (m_left == 1) ? (N'(1) << m_pick) : '0;
      m_busy  = 1'b1;
      m_ptr   = (m_pick + 1) % N;
    end
  end

  // Observation logs for the directed scenarios.
  int           grant_log[$];
  int           gstart_log[$];
  int           done_log[$];
  int           busy_cnt;
  int           n_cyc = 0;
  logic         busy_prev = 1'b0;
  logic [N-1:0] done_acc;
  logic         auto_drop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int grant_at(input int i);
    return (i < grant_log.size()) ? grant_log[i] : -1;
  endfunction

  function automatic int done_offset(input int i);
    return (i < done_log.size() && i < gstart_log.size()) ? done_log[i] - gstart_log[i] : -1;
  endfunction

  function automatic int done_gap(input int i);
    return (i + 1 < done_log.size()) ? done_log[i+1] - done_log[i] : -1;
  endfunction

  task automatic clear_logs();
    grant_log.delete();
    gstart_log.delete();
    done_log.delete();
    busy_cnt = 0;
    done_acc = '0;
  endtask

  // One clock cycle: compare against the model at the falling edge, then log.
  task automatic cyc();
    @(negedge clk);
    n_cyc++;
    check("busy", busy, m_busy);
    check("done", done, m_done);
    if (m_busy) check("grant_id", grant_id, m_owner);
    if (busy && !busy_prev) begin
      grant_log.push_back(int'(grant_id));
      gstart_log.push_back(n_cyc);
    end
    if (busy) busy_cnt++;
    if (done != '0) done_log.push_back(n_cyc);
    done_acc  = done_acc | done;
    busy_prev = busy;
    if (auto_drop) req = req & ~done;
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_gid", grant_id, 0);
    cyc();
    cyc();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; req = '0; cycles = '0; auto_drop = 1'b0;
    clear_logs();

    // Reset state, then a single request of 5 cycles.
    do_reset();
    clear_logs();
    auto_drop = 1'b1;
    cycles[1] = 4'd5; req = 4'b0010;
    repeat (10) cyc();
    check("single_busy_cycles", busy_cnt, 5);
    check("single_grant", grant_at(0), 1);
    check("single_done_count", done_log.size(), 1);
    check("single_done_in_5th", done_offset(0), 4);

    // Contention after reset: grants 0,1,3 with done pulses 4 cycles apart.
    do_reset();
    clear_logs();
    cycles = {4'd3, 4'd3, 4'd3, 4'd3}; req = 4'b1011;
    repeat (16) cyc();
    check("rr_grant0", grant_at(0), 0);
    check("rr_grant1", grant_at(1), 1);
    check("rr_grant2", grant_at(2), 3);
    check("rr_gap0", done_gap(0), 4);
    check("rr_gap1", done_gap(1), 4);

    // Zero delay behaves as one cycle.
    clear_logs();
    cycles[2] = 4'd0; req = 4'b0100;
    repeat (5) cyc();
    check("zero_busy_cycles", busy_cnt, 1);
    check("zero_done_bits", done_acc, 4'b0100);
    check("zero_done_same_cycle", done_offset(0), 0);

    // Maximum delay for W=4 runs the full 15 cycles without wrapping.
    clear_logs();
    cycles[0] = 4'd15; req = 4'b0001;
    repeat (20) cyc();
    check("max_busy_cycles", busy_cnt, 15);
    check("max_done_count", done_log.size(), 1);
    check("max_done_in_15th", done_offset(0), 14);

    // Abort: requester 2 drops in its 4th busy cycle, pending 3 follows.
    clear_logs();
    cycles[2] = 4'd10; cycles[3] = 4'd2; req = 4'b0100;
    for (int k = 0; k < 10 && busy_cnt == 0; k++) cyc();
    check("abort_granted", grant_at(0), 2);
    req[3] = 1'b1;
    for (int k = 0; k < 10 && busy_cnt < 4; k++) cyc();
    check("abort_reached_4th", busy_cnt, 4);
    req[2] = 1'b0;
    cyc();
    check("abort_busy_low", busy, 0);
    cyc();
    check("abort_next_busy", busy, 1);
    check("abort_next_gid", grant_id, 3);
    repeat (6) cyc();
    check("abort_done_bits", done_acc, 4'b1000);

    // Reset in the 3rd busy cycle of an 8-cycle delay; regrant restarts at ptr 0.
    clear_logs();
    cycles[1] = 4'd8; cycles[3] = 4'd2; req = 4'b1010;
    for (int k = 0; k < 20 && busy_cnt < 3; k++) cyc();
    check("mid_rst_first_grant", grant_at(0), 1);
    check("mid_rst_third_busy", busy_cnt, 3);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_async_busy", busy, 0);
    check("mid_rst_async_gid", grant_id, 0);
    check("mid_rst_async_done", done, 0);
    check("mid_rst_no_done", done_acc, 0);
    cyc();
    cyc();
    rst = 1'b1;
    grant_log.delete();
    for (int k = 0; k < 5 && grant_log.size() == 0; k++) cyc();
    check("mid_rst_regrant", grant_at(0), 1);
    repeat (20) cyc();
    check("mid_rst_then_3", grant_at(1), 3);

    // Held requests alternate; changing cycles mid-count leaves that delay alone.
    clear_logs();
    auto_drop = 1'b0;
    cycles[0] = 4'd4; cycles[1] = 4'd3; req = 4'b0011;
    for (int k = 0; k < 5 && busy_cnt == 0; k++) cyc();
    cycles[0] = 4'd12;
    repeat (30) cyc();
    check("held_grant0", grant_at(0), 0);
    check("held_grant1", grant_at(1), 1);
    check("held_grant2", grant_at(2), 0);
    check("held_grant3", grant_at(3), 1);
    check("held_first_delay", done_offset(0), 3);
    check("held_second_delay", done_offset(1), 2);
    check("held_third_delay", done_offset(2), 11);
    req = '0;
    repeat (3) cyc();

    // Random traffic with occasional withdrawals and one reset, against the model.
    auto_drop = 1'b1;
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i]) begin
          if ($urandom_range(3) == 0) req[i] = 1'b1;
        end else if ($urandom_range(40) == 0) begin
          req[i] = 1'b0;
        end
        cycles[i] = ($urandom_range(9) == 0) ? W'(15) : W'($urandom_range(4));
      end
      if (t == 200) do_reset();
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/delay_arbiter.md
DELAY_ARBITER -- requirements
Module: delay_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters, 2..8.
REQ-002 Parameter W, default 16: delay counter width in bits.
REQ-003 clk  input  1  single clock; all state on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low; clears all state while low.
REQ-005 req  input  N_REQ  level request per requester; held high until that requester's done or until it aborts.
REQ-006 cycles  input  N_REQ x W  requested delay per requester, in clk cycles; sampled only at grant.
REQ-007 busy  output  1  high while a delay is being timed.
REQ-008 grant_id  output  clog2(N_REQ)  index of the current owner; valid only while busy=1.
REQ-009 done  output  N_REQ  one-cycle completion pulse; at most one bit high per cycle.

Function
REQ-010 States SHALL be IDLE, COUNT and DONE only; any other encoding SHALL return to IDLE on the next edge.
REQ-011 In IDLE with any req bit high, the block SHALL grant one requester at the edge and enter COUNT.
- Selection is round-robin: search starts at index ptr, wrapping modulo N_REQ.
- ptr resets to 0.
- ptr SHALL be set to grant_id+1 (mod N_REQ) on each grant.
REQ-012 At grant, the block SHALL latch D = max(cycles[grant_id], 1) into the counter, so that cycles=0 behaves as 1.
REQ-013 Let G be the first cycle with busy=1. done[grant_id] SHALL be high in cycle G+D-1 only, with busy=1 in that cycle.
REQ-014 In the cycle after done, the block SHALL be in DONE with busy=0, then return to IDLE.
- Next grant earliest at cycle G+D+1.
REQ-015 If req[grant_id] is low in any COUNT cycle before the done cycle, the block SHALL abort.
- No done pulse.
- busy=0 from the next cycle.
- Block passes through DONE to IDLE; ptr keeps its updated value.
REQ-016 Requests arriving during COUNT or DONE SHALL wait, with no loss and no reordering beyond round-robin order.
REQ-017 A requester still high after its own done SHALL be treated as a new request at the lowest round-robin priority.
REQ-018 The counter SHALL be a W-bit down-counter that never wraps.
- D = 2^W-1 is supported.
- Counting stops at terminal count.
REQ-019 Changes on cycles[] after grant SHALL have no effect on the delay in progress.

Reset
REQ-020 While rst=0, the following SHALL hold asynchronously: state=IDLE, ptr=0, counter=0, busy=0, grant_id=0, done=0.
REQ-021 Reset asserted mid-COUNT SHALL abandon the delay with no done pulse.
- After rst rises, the first grant occurs no earlier than the first rising edge with rst=1.

Structure
REQ-022 Package delay_arb_pkg SHALL hold the state enum type and the helper function for the index width (clog2).
REQ-023 One sub-module, delay_counter, SHALL hold the loadable W-bit down-counter.
- Inputs: clk, rst, load, value.
- Output: terminal flag.
- Arbitration and the FSM stay in delay_arbiter.
REQ-024 All outputs SHALL be registered; no combinational path from req to done.

Verification
REQ-025 Single request: req[1]=1, cycles[1]=5, from IDLE.
- Required: busy=1 for 5 cycles, grant_id=1.
- done[1] high in the 5th busy cycle only.
REQ-026 Contention: req=4'b1011 at once, after reset, cycles all 3, each req dropped after its done.
- Grant order 0, 1, 3.
- Done pulses spaced 4 cycles apart.
REQ-027 Zero and maximum delay.
- cycles=0: exactly 1 busy cycle, with done in it.
- W=4, cycles=15: exactly 15 busy cycles, no wrap.
REQ-028 Abort: req[2] granted with cycles=10, dropped in the 4th busy cycle.
- done stays 0.
- busy=0 from the next cycle.
- A pending req[3] is granted 2 cycles later.
REQ-029 Reset mid-COUNT: rst=0 in the 3rd busy cycle of a cycles=8 delay.
- Outputs clear asynchronously; no done.
- A held req is regranted after rst rises, with ptr=0 ordering.
REQ-030 Held request: req[0] and req[1] held high continuously.
- Grants alternate 0, 1, 0, 1.
- cycles[] changed mid-count leaves the current delay unchanged.
